flight_arm_sequencer: RTL and testbench
=======================================

FLIGHT_ARM_SEQUENCER -- requirements
Module: flight_arm_sequencer

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, meaning clock frequency used to derive the 1 ms tick.
REQ-002 SHALL have parameter SBUS_TO_MS, default 100, meaning SBUS link timeout in ms.
REQ-003 SHALL have parameter IMU_TO_MS, default 20, meaning IMU data timeout in ms.
REQ-004 SHALL have parameters ARM_HOLD_MS (default 500), CAL_HIGH_MS (default 2000) and CAL_LOW_MS (default 2000), meaning the arm-hold time, calibration-high time and calibration-low time.
REQ-005 SHALL have port clk, input, 1 bit: the single clock (50 MHz).
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port ch2, input, 11 bits: throttle channel (SBUS raw, 172..1811).
REQ-008 SHALL have port ch4, input, 11 bits: ESC calibration switch channel.
REQ-009 SHALL have port ch5, input, 11 bits: kill switch channel.
REQ-010 SHALL have port sbus_valid, input, 1 bit: one-cycle pulse marking a new decoded SBUS frame.
REQ-011 SHALL have port imu_flag, input, 1 bit: one-cycle pulse marking a new IMU sample.
REQ-012 SHALL have port thr_cmd, output, 11 bits: throttle command to the attitude controller and PWM stage.
REQ-013 SHALL have port motor_en, output, 1 bit: high only in ARMED.
REQ-014 SHALL have port state, output, 3 bits: current state encoding.
REQ-015 SHALL have port link_ok, output, 1 bit: both SBUS and IMU are fresh.
REQ-016 SHALL have port fault, output, 1 bit: high in FAILSAFE.

Function
REQ-017 SHALL generate a 1 ms tick: a prescaler counts 0..CLK_HZ/1000-1 and pulses the tick on wrap.
REQ-018 SHALL keep one saturating ms-age counter per link; the matching pulse clears it to 0, and when a pulse and a tick occur in the same cycle, the clear wins.
REQ-019 SHALL define sbus_ok as sbus_age < SBUS_TO_MS, imu_ok as imu_age < IMU_TO_MS, and link_ok as sbus_ok AND imu_ok.
REQ-020 SHALL sample ch2/ch4/ch5 into internal registers only on sbus_valid; all decisions use the sampled values.
REQ-021 SHALL derive switch levels from the sampled values: kill = ch5_s >= 1400, cal = ch4_s >= 1400, thr_low = ch2_s <= 250, thr_high = ch2_s >= 1700.
REQ-022 SHALL implement the states DISARMED=0, ARMED=1, CAL_HIGH=2, CAL_LOW=3, FAILSAFE=4; codes 5..7 are illegal and SHALL go to DISARMED.
REQ-023 DISARMED SHALL go to CAL_HIGH when cal AND thr_high AND link_ok AND NOT kill.
REQ-024 DISARMED SHALL go to ARMED after NOT cal AND thr_low AND link_ok AND NOT kill has held continuously for ARM_HOLD_MS ticks; any break clears the hold counter.
REQ-025 ARMED SHALL apply this transition priority: kill -> DISARMED, else NOT link_ok -> FAILSAFE, else stay.
REQ-026 CAL_HIGH SHALL go to CAL_LOW after CAL_HIGH_MS ticks, and CAL_LOW SHALL go to DISARMED after CAL_LOW_MS ticks; kill SHALL abort either state to DISARMED.
REQ-027 FAILSAFE SHALL go to DISARMED only when link_ok AND kill (operator acknowledgement); otherwise it stays.
REQ-028 SHALL drive thr_cmd as follows: DISARMED/CAL_LOW/FAILSAFE -> 172; CAL_HIGH -> 1811; ARMED -> ch2_s clamped to [172,1811].
REQ-029 SHALL register all outputs: one cycle of latency from a sampled-condition change to the state/output change.
REQ-030 SHALL share one ms timer between the arm hold and the calibration phases, cleared on every state change.

Reset
REQ-031 On reset assertion, SHALL immediately force state=DISARMED, thr_cmd=172, motor_en=0, fault=0 and link_ok=0.
REQ-032 On reset, SHALL force both ages to saturate at their timeouts (links not fresh), clear the sampled channels to 0, and clear the prescaler and hold timer to 0.
REQ-033 Reset mid-calibration or while ARMED SHALL abort to DISARMED with no residual timer state.

Structure
REQ-034 SHALL place the state encoding, the SBUS limits (172, 1811, 250, 1400, 1700) and the 11-bit channel width in the shared package flight_pkg.
REQ-035 SHALL implement the age counter as the sub-module ms_watchdog (parameter TIMEOUT_MS; inputs tick and kick; output ok), instantiated twice.
REQ-036 Synthesizable size SHALL be 120-400 lines total.

Verification (bench with CLK_HZ=1000, so one tick per cycle)
REQ-037 Arm: with both links pulsing every 5 cycles, ch2=200, ch4=172, ch5=172, the block SHALL reach ARMED after 500 ticks with motor_en=1, and then ch2=1000 SHALL give thr_cmd=1000.
REQ-038 Clamp: while ARMED, ch2=100 SHALL give thr_cmd=172, and ch2=2000 SHALL give thr_cmd=1811.
REQ-039 Calibration: ch4=1811, ch2=1800 SHALL give CAL_HIGH with thr_cmd=1811 for 2000 ticks, then CAL_LOW with thr_cmd=172 for 2000 ticks, then DISARMED.
REQ-040 Failsafe: while ARMED, stopping imu_flag SHALL give FAILSAFE on the 20th tick with thr_cmd=172 and fault=1; resuming the pulses with ch5=1811 SHALL give DISARMED.
REQ-041 Kill priority: ch5=1811 and an IMU timeout in the same cycle while ARMED SHALL give DISARMED, not FAILSAFE.
REQ-042 Reset mid-CAL_HIGH (rst=0 for 3 cycles) SHALL give DISARMED with thr_cmd=172 immediately, and no re-entry to CAL_HIGH until a fresh sbus_valid and imu_flag arrive.

Source files
------------

// File: rtl/flight_pkg.sv
// rtl/flight_pkg.sv - shared state encoding, SBUS channel limits and throttle clamp
package flight_pkg;

    localparam int CH_W = 11;

    localparam logic [CH_W-1:0] SBUS_MIN     = 11'd172;
    localparam logic [CH_W-1:0] SBUS_MAX     = 11'd1811;
    localparam logic [CH_W-1:0] THR_LOW_MAX  = 11'd250;
    localparam logic [CH_W-1:0] SW_ON_MIN    = 11'd1400;
    localparam logic [CH_W-1:0] THR_HIGH_MIN = 11'd1700;

    typedef enum logic [2:0] {
        ST_DISARMED = 3'd0,
        ST_ARMED    = 3'd1,
        ST_CAL_HIGH = 3'd2,
        ST_CAL_LOW  = 3'd3,
        ST_FAILSAFE = 3'd4
    } state_e;

    function automatic logic [CH_W-1:0] clamp_thr(input logic [CH_W-1:0] v);
        if (v < SBUS_MIN)      return SBUS_MIN;
        else if (v > SBUS_MAX) return SBUS_MAX;
        else                   return v;
    endfunction

endpackage

// File: rtl/ms_watchdog.sv
// rtl/ms_watchdog.sv - saturating millisecond age counter, ok while age < TIMEOUT_MS
module ms_watchdog #(
    parameter int TIMEOUT_MS = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic kick,
    output logic ok
);

    localparam int AW = $clog2(TIMEOUT_MS + 1);

    logic [AW-1:0] age_q;

    // Reset parks the age at the timeout so a link is stale until its first pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            age_q <= AW'(TIMEOUT_MS);
        end else if (kick) begin
            age_q <= '0;
        end else if (tick && (age_q < AW'(TIMEOUT_MS))) begin
            age_q <= age_q + AW'(1);
        end
    end

    assign ok = (age_q < AW'(TIMEOUT_MS));

endmodule

// File: rtl/flight_arm_sequencer.sv
// rtl/flight_arm_sequencer.sv - arm/calibrate/failsafe sequencer driving throttle and motor enable
module flight_arm_sequencer
    import flight_pkg::*;
#(
    parameter int CLK_HZ      = 50000000,
    parameter int SBUS_TO_MS  = 100,
    parameter int IMU_TO_MS   = 20,
    parameter int ARM_HOLD_MS = 500,
    parameter int CAL_HIGH_MS = 2000,
    parameter int CAL_LOW_MS  = 2000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [CH_W-1:0] ch2,
    input  logic [CH_W-1:0] ch4,
    input  logic [CH_W-1:0] ch5,
    input  logic            sbus_valid,
    input  logic            imu_flag,
    output logic [CH_W-1:0] thr_cmd,
    output logic            motor_en,
    output logic [2:0]      state,
    output logic            link_ok,
    output logic            fault
);

    localparam int DIV = CLK_HZ / 1000;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TW  = 16;

    logic [PW-1:0]   presc_q;
    logic            tick;
    logic [CH_W-1:0] ch2_s_q, ch4_s_q, ch5_s_q;
    logic            sbus_ok, imu_ok, link_now;
    logic            kill, cal, thr_low, thr_high, arm_cond;
    state_e          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [CH_W-1:0] thr_cmd_q;
    logic            motor_en_q, link_ok_q, fault_q;

    assign tick = (presc_q == PW'(DIV - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      presc_q <= '0;
        else if (tick) presc_q <= '0;
        else           presc_q <= presc_q + PW'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ch2_s_q <= '0;
            ch4_s_q <= '0;
            ch5_s_q <= '0;
        end else if (sbus_valid) begin
            ch2_s_q <= ch2;
            ch4_s_q <= ch4;
            ch5_s_q <= ch5;
        end
    end

    ms_watchdog #(.TIMEOUT_MS(SBUS_TO_MS)) u_sbus_wd (
        .clk(clk), .rst(rst), .tick(tick), .kick(sbus_valid), .ok(sbus_ok)
    );

    ms_watchdog #(.TIMEOUT_MS(IMU_TO_MS)) u_imu_wd (
        .clk(clk), .rst(rst), .tick(tick), .kick(imu_flag), .ok(imu_ok)
    );

    assign link_now = sbus_ok & imu_ok;
    assign kill     = (ch5_s_q >= SW_ON_MIN);
    assign cal      = (ch4_s_q >= SW_ON_MIN);
    assign thr_low  = (ch2_s_q <= THR_LOW_MAX);
    assign thr_high = (ch2_s_q >= THR_HIGH_MIN);
    assign arm_cond = !cal && thr_low && link_now && !kill;

    // One timer serves the arm hold and both calibration phases.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        case (state_q)
            ST_DISARMED: begin
                if (cal && thr_high && link_now && !kill) begin
                    state_d = ST_CAL_HIGH;
                end else if (arm_cond) begin
                    if (tick) begin
                        if (timer_q == TW'(ARM_HOLD_MS - 1)) state_d = ST_ARMED;
                        else                                 timer_d = timer_q + TW'(1);
                    end
                end else begin
                    timer_d = '0;
                end
            end
            ST_ARMED: begin
                if (kill)           state_d = ST_DISARMED;
                else if (!link_now) state_d = ST_FAILSAFE;
            end
            ST_CAL_HIGH: begin
                if (kill) begin
                    state_d = ST_DISARMED;
                end else if (tick) begin
                    if (timer_q == TW'(CAL_HIGH_MS - 1)) state_d = ST_CAL_LOW;
                    else                                 timer_d = timer_q + TW'(1);
                end
            end
            ST_CAL_LOW: begin
                if (kill) begin
                    state_d = ST_DISARMED;
                end else if (tick) begin
                    if (timer_q == TW'(CAL_LOW_MS - 1)) state_d = ST_DISARMED;
                    else                                timer_d = timer_q + TW'(1);
                end
            end
            ST_FAILSAFE: begin
                if (link_now && kill) state_d = ST_DISARMED;
            end
            default: state_d = ST_DISARMED;
        endcase
        if (state_d != state_q) timer_d = '0;
    end

    // Outputs are registered from the next state so they move together with it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_DISARMED;
            timer_q    <= '0;
            thr_cmd_q  <= SBUS_MIN;
            motor_en_q <= 1'b0;
            link_ok_q  <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            motor_en_q <= (state_d == ST_ARMED);
            fault_q    <= (state_d == ST_FAILSAFE);
            link_ok_q  <= link_now;
            case (state_d)
                ST_ARMED:    thr_cmd_q <= clamp_thr(ch2_s_q);
                ST_CAL_HIGH: thr_cmd_q <= SBUS_MAX;
                default:     thr_cmd_q <= SBUS_MIN;
            endcase
        end
    end

    assign state    = state_q;
    assign thr_cmd  = thr_cmd_q;
    assign motor_en = motor_en_q;
    assign link_ok  = link_ok_q;
    assign fault    = fault_q;

endmodule

// File: tb/tb_flight_arm_sequencer.sv
// tb/tb_flight_arm_sequencer.sv - directed bench for flight_arm_sequencer at one tick per cycle
module tb_flight_arm_sequencer;

    localparam logic [2:0] S_DIS = 3'd0;
    localparam logic [2:0] S_ARM = 3'd1;
    localparam logic [2:0] S_CH  = 3'd2;
    localparam logic [2:0] S_CL  = 3'd3;
    localparam logic [2:0] S_FS  = 3'd4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [10:0] ch2 = '0, ch4 = '0, ch5 = '0;
    logic        sbus_valid = 1'b0, imu_flag = 1'b0;
    logic [10:0] thr_cmd;
    logic        motor_en, link_ok, fault;
    logic [2:0]  state;

    int   passed = 0;
    int   total  = 0;
    int   cyc    = 0;
    logic sbus_en = 1'b0;
    logic imu_en  = 1'b0;

    flight_arm_sequencer #(.CLK_HZ(1000)) dut (
        .clk(clk), .rst(rst), .ch2(ch2), .ch4(ch4), .ch5(ch5),
        .sbus_valid(sbus_valid), .imu_flag(imu_flag),
        .thr_cmd(thr_cmd), .motor_en(motor_en), .state(state),
        .link_ok(link_ok), .fault(fault)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Both links pulse every 5 cycles when enabled.
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            sbus_valid = sbus_en && (cyc % 5 == 0);
            imu_flag   = imu_en && (cyc % 5 == 0);
            @(posedge clk);
            #1;
            cyc++;
            sbus_valid = 1'b0;
            imu_flag   = 1'b0;
        end
    endtask

    task automatic manual_cycle(input logic sv, input logic im);
        sbus_valid = sv;
        imu_flag   = im;
        @(posedge clk);
        #1;
        cyc++;
        sbus_valid = 1'b0;
        imu_flag   = 1'b0;
    endtask

    task automatic run_until(input logic [2:0] st, input int max);
        int used = 0;
        while (state !== st && used < max) begin
            run(1);
            used++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        run(2);
        total++; if (state !== S_DIS) $display("FAIL reset_state: got %0d expected %0d", state, S_DIS); else passed++;
        total++; if (thr_cmd !== 11'd172) $display("FAIL reset_thr: got %0d expected 172", thr_cmd); else passed++;
        total++; if (motor_en !== 1'b0) $display("FAIL reset_motor_en: got %0b expected 0", motor_en); else passed++;
        total++; if (fault !== 1'b0) $display("FAIL reset_fault: got %0b expected 0", fault); else passed++;
        total++; if (link_ok !== 1'b0) $display("FAIL reset_link_ok: got %0b expected 0", link_ok); else passed++;
        rst = 1'b1;
        run(2);
        total++; if (link_ok !== 1'b0) $display("FAIL stale_link_ok: got %0b expected 0", link_ok); else passed++;
    endtask

    task automatic test_arm;
        ch2 = 11'd200; ch4 = 11'd172; ch5 = 11'd172;
        cyc = 0; sbus_en = 1'b1; imu_en = 1'b1;
        run(3);
        total++; if (link_ok !== 1'b1) $display("FAIL arm_link_ok: got %0b expected 1", link_ok); else passed++;
        run(200);
        ch2 = 11'd1000;
        run(10);
        ch2 = 11'd200;
        total++; if (state !== S_DIS) $display("FAIL arm_break_state: got %0d expected %0d", state, S_DIS); else passed++;
        run(480);
        total++; if (state !== S_DIS) $display("FAIL arm_hold_restart: got %0d expected %0d", state, S_DIS); else passed++;
        total++; if (motor_en !== 1'b0) $display("FAIL arm_hold_motor: got %0b expected 0", motor_en); else passed++;
        run_until(S_ARM, 40);
        total++; if (state !== S_ARM) $display("FAIL arm_state: got %0d expected %0d", state, S_ARM); else passed++;
        total++; if (motor_en !== 1'b1) $display("FAIL arm_motor_en: got %0b expected 1", motor_en); else passed++;
        total++; if (thr_cmd !== 11'd200) $display("FAIL arm_thr_200: got %0d expected 200", thr_cmd); else passed++;
        ch2 = 11'd1000;
        run(6);
        total++; if (thr_cmd !== 11'd1000) $display("FAIL arm_thr_1000: got %0d expected 1000", thr_cmd); else passed++;
    endtask

    task automatic test_clamp;
        ch2 = 11'd100;
        run(6);
        total++; if (thr_cmd !== 11'd172) $display("FAIL clamp_low: got %0d expected 172", thr_cmd); else passed++;
        ch2 = 11'd2000;
        run(6);
        total++; if (thr_cmd !== 11'd1811) $display("FAIL clamp_high: got %0d expected 1811", thr_cmd); else passed++;
        ch2 = 11'd1811;
        run(6);
        total++; if (thr_cmd !== 11'd1811) $display("FAIL clamp_edge_max: got %0d expected 1811", thr_cmd); else passed++;
        ch2 = 11'd1000;
        run(6);
        total++; if (state !== S_ARM) $display("FAIL clamp_still_armed: got %0d expected %0d", state, S_ARM); else passed++;
    endtask

    task automatic test_failsafe;
        imu_en = 1'b0;
        manual_cycle(1'b0, 1'b1);
        run(19);
        total++; if (state !== S_ARM) $display("FAIL fs_before_timeout: got %0d expected %0d", state, S_ARM); else passed++;
        run_until(S_FS, 3);
        total++; if (state !== S_FS) $display("FAIL fs_state: got %0d expected %0d", state, S_FS); else passed++;
        total++; if (fault !== 1'b1) $display("FAIL fs_fault: got %0b expected 1", fault); else passed++;
        total++; if (thr_cmd !== 11'd172) $display("FAIL fs_thr: got %0d expected 172", thr_cmd); else passed++;
        total++; if (motor_en !== 1'b0) $display("FAIL fs_motor_en: got %0b expected 0", motor_en); else passed++;
        total++; if (link_ok !== 1'b0) $display("FAIL fs_link_ok: got %0b expected 0", link_ok); else passed++;
        imu_en = 1'b1;
        run(15);
        total++; if (state !== S_FS) $display("FAIL fs_no_ack_hold: got %0d expected %0d", state, S_FS); else passed++;
        total++; if (link_ok !== 1'b1) $display("FAIL fs_link_back: got %0b expected 1", link_ok); else passed++;
        ch5 = 11'd1811;
        run_until(S_DIS, 12);
        total++; if (state !== S_DIS) $display("FAIL fs_ack_state: got %0d expected %0d", state, S_DIS); else passed++;
        total++; if (fault !== 1'b0) $display("FAIL fs_ack_fault: got %0b expected 0", fault); else passed++;
        ch5 = 11'd172; ch2 = 11'd200;
        run_until(S_ARM, 560);
        total++; if (state !== S_ARM) $display("FAIL rearm_state: got %0d expected %0d", state, S_ARM); else passed++;
    endtask

    task automatic test_kill_priority;
        logic saw_fs = 1'b0;
        sbus_en = 1'b0; imu_en = 1'b0;
        manual_cycle(1'b1, 1'b1);
        run(19);
        total++; if (state !== S_ARM) $display("FAIL kill_pre_state: got %0d expected %0d", state, S_ARM); else passed++;
        ch5 = 11'd1811;
        manual_cycle(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            run(1);
            if (state === S_FS) saw_fs = 1'b1;
        end
        total++; if (saw_fs !== 1'b0) $display("FAIL kill_no_failsafe: got saw_fs=%0b expected 0", saw_fs); else passed++;
        total++; if (state !== S_DIS) $display("FAIL kill_state: got %0d expected %0d", state, S_DIS); else passed++;
        ch5 = 11'd172; ch2 = 11'd1000;
        sbus_en = 1'b1; imu_en = 1'b1;
    endtask

    task automatic test_calibration;
        ch4 = 11'd1811; ch2 = 11'd1800; ch5 = 11'd172;
        run_until(S_CH, 15);
        total++; if (state !== S_CH) $display("FAIL cal_high_state: got %0d expected %0d", state, S_CH); else passed++;
        total++; if (thr_cmd !== 11'd1811) $display("FAIL cal_high_thr: got %0d expected 1811", thr_cmd); else passed++;
        total++; if (motor_en !== 1'b0) $display("FAIL cal_high_motor: got %0b expected 0", motor_en); else passed++;
        run(1985);
        total++; if (state !== S_CH) $display("FAIL cal_high_hold: got %0d expected %0d", state, S_CH); else passed++;
        run_until(S_CL, 30);
        total++; if (state !== S_CL) $display("FAIL cal_low_state: got %0d expected %0d", state, S_CL); else passed++;
        total++; if (thr_cmd !== 11'd172) $display("FAIL cal_low_thr: got %0d expected 172", thr_cmd); else passed++;
        ch4 = 11'd172; ch2 = 11'd1000;
        run(1985);
        total++; if (state !== S_CL) $display("FAIL cal_low_hold: got %0d expected %0d", state, S_CL); else passed++;
        run_until(S_DIS, 30);
        total++; if (state !== S_DIS) $display("FAIL cal_done_state: got %0d expected %0d", state, S_DIS); else passed++;
        total++; if (thr_cmd !== 11'd172) $display("FAIL cal_done_thr: got %0d expected 172", thr_cmd); else passed++;
    endtask

    task automatic test_reset_mid_cal;
        ch4 = 11'd1811; ch2 = 11'd1800; ch5 = 11'd172;
        run_until(S_CH, 15);
        run(100);
        total++; if (state !== S_CH) $display("FAIL rcal_pre_state: got %0d expected %0d", state, S_CH); else passed++;
        rst = 1'b0;
        #1;
        total++; if (state !== S_DIS) $display("FAIL rcal_async_state: got %0d expected %0d", state, S_DIS); else passed++;
        total++; if (thr_cmd !== 11'd172) $display("FAIL rcal_async_thr: got %0d expected 172", thr_cmd); else passed++;
        total++; if (link_ok !== 1'b0) $display("FAIL rcal_async_link: got %0b expected 0", link_ok); else passed++;
        sbus_en = 1'b0; imu_en = 1'b0;
        run(3);
        rst = 1'b1;
        run(20);
        total++; if (state !== S_DIS) $display("FAIL rcal_no_reentry: got %0d expected %0d", state, S_DIS); else passed++;
        sbus_en = 1'b1; imu_en = 1'b1;
        run_until(S_CH, 15);
        total++; if (state !== S_CH) $display("FAIL rcal_reentry: got %0d expected %0d", state, S_CH); else passed++;
        run(1985);
        total++; if (state !== S_CH) $display("FAIL rcal_fresh_timer: got %0d expected %0d", state, S_CH); else passed++;
    endtask

    initial begin
        test_reset();
        test_arm();
        test_clamp();
        test_failsafe();
        test_kill_priority();
        test_calibration();
        test_reset_mid_cal();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
